// File: rtl/vec_hazard_ctrl_if.sv
// Pipeline-side signal bundle for vec_hazard_ctrl: hazard inputs, memory lane
// handshake and the pipe-register enables/clears.
// master: pipeline/memory side, drives addresses, write flags and lane_ack.
// slave:  the hazard controller.
interface vec_hazard_ctrl_if #(
  parameter int unsigned IDX_W = 3
);
  logic [3:0]       ra1D, ra2D;
  logic [3:0]       ra1E, ra2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW;
  logic             MemtoRegE;
  logic             MemtoRegM, MemWriteM;
  logic             lane_ack;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             EN1, EN2, EN3, EN4;
  logic             CLR2;
  logic             lane_req;
  logic             lane_we;
  logic [IDX_W-1:0] lane_idx;
  logic             lane_load;
  logic             mem_err;

  modport master (
    output ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, lane_ack,
    input  ForwardAE, ForwardBE, EN1, EN2, EN3, EN4, CLR2,
    input  lane_req, lane_we, lane_idx, lane_load, mem_err
  );

  modport slave (
    input  ra1D, ra2D, ra1E, ra2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM, lane_ack,
    output ForwardAE, ForwardBE, EN1, EN2, EN3, EN4, CLR2,
    output lane_req, lane_we, lane_idx, lane_load, mem_err
  );
endinterface

// File: rtl/vec_hazard_ctrl.sv
// Hazard and vector memory-sequencing controller for the 5-stage vector pipe.
// Combinational forwarding selects and load-use stall; a lane-serial FSM walks
// a vector memop in M through the one-lane memory port, freezing the pipe.
// Optional macro VEC_HAZARD_TIMEOUT_EN adds a per-lane ack timeout and a
// sticky mem_err flag; without it BUSY waits for lane_ack indefinitely.
module vec_hazard_ctrl #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  vec_hazard_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lane_idx_q, lane_idx_d;
  logic             lane_we_q, lane_we_d;
  logic             lane_req_q, lane_req_d;
  logic             lane_load_c;
  logic             ldstall;
  logic             memop_m;
  logic             freeze;

`ifdef VEC_HAZARD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^{32'(TIMEOUT)};
`endif

  // Operand forwarding: M stage wins over W stage, R0 treated like any register.
  always_comb begin
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    if (bus.RegWriteM && (bus.WA3M == bus.ra1E))      bus.ForwardAE = 2'b10;
    else if (bus.RegWriteW && (bus.WA3W == bus.ra1E)) bus.ForwardAE = 2'b01;
    if (bus.RegWriteM && (bus.WA3M == bus.ra2E))      bus.ForwardBE = 2'b10;
    else if (bus.RegWriteW && (bus.WA3W == bus.ra2E)) bus.ForwardBE = 2'b01;
  end

  assign ldstall = bus.MemtoRegE && ((bus.WA3E == bus.ra1D) || (bus.WA3E == bus.ra2D));
  assign memop_m = bus.MemtoRegM || bus.MemWriteM;
  assign freeze  = ((state_q == IDLE) && memop_m) || (state_q == BUSY);

  // Pipe-register enables: a memop freeze overrides the load-use bubble.
  always_comb begin
    bus.EN1  = 1'b1;
    bus.EN2  = 1'b1;
    bus.EN3  = 1'b1;
    bus.EN4  = 1'b1;
    bus.CLR2 = 1'b0;
    if (freeze) begin
      bus.EN1 = 1'b0;
      bus.EN2 = 1'b0;
      bus.EN3 = 1'b0;
      bus.EN4 = 1'b0;
    end else if (ldstall) begin
      bus.EN1  = 1'b0;
      bus.EN2  = 1'b0;
      bus.CLR2 = 1'b1;
    end
  end

  // Lane sequencer next-state: one lane per acknowledged access.
  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    lane_we_d   = lane_we_q;
    lane_load_c = 1'b0;
`ifdef VEC_HAZARD_TIMEOUT_EN
    cnt_d       = '0;
    mem_err_d   = mem_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (memop_m) begin
          state_d    = BUSY;
          lane_idx_d = '0;
          lane_we_d  = bus.MemWriteM;
        end
      end
      BUSY: begin
        if (bus.lane_ack) begin
          lane_load_c = !lane_we_q;
          if (lane_idx_q == IDX_W'(LANES - 1)) state_d = DONE;
          else                                 lane_idx_d = lane_idx_q + IDX_W'(1);
        end
`ifdef VEC_HAZARD_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = DONE;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    lane_req_d = (state_d == BUSY);
  end

  // Sequencer state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      lane_idx_q <= '0;
      lane_we_q  <= 1'b0;
      lane_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_idx_q <= lane_idx_d;
      lane_we_q  <= lane_we_d;
      lane_req_q <= lane_req_d;
    end
  end

`ifdef VEC_HAZARD_TIMEOUT_EN
  // Ack-wait counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign bus.mem_err = mem_err_q;
`else
  assign bus.mem_err = 1'b0;
`endif

  assign bus.lane_req  = lane_req_q;
  assign bus.lane_we   = lane_we_q;
  assign bus.lane_idx  = lane_idx_q;
  assign bus.lane_load = lane_load_c;

endmodule

// File: tb/tb_vec_hazard_ctrl.sv
// Directed self-checking bench for vec_hazard_ctrl.
module tb_vec_hazard_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  vec_hazard_ctrl_if bus ();

  vec_hazard_ctrl #(.LANES(8), .TIMEOUT(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] ens();
    return {bus.EN1, bus.EN2, bus.EN3, bus.EN4};
  endfunction

  int en_low;
  int loads;
  int busy_cnt;
  int cyc;

  initial begin
    bus.ra1D = 4'd0; bus.ra2D = 4'd0; bus.ra1E = 4'd0; bus.ra2E = 4'd0;
    bus.WA3E = 4'd0; bus.WA3M = 4'd0; bus.WA3W = 4'd0;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.MemtoRegE = 1'b0;
    bus.MemtoRegM = 1'b0; bus.MemWriteM = 1'b0; bus.lane_ack = 1'b0;

    // Reset state
    #12;
    check("rst_en", 32'(ens()), 32'hF);
    check("rst_req", 32'(bus.lane_req), 32'd0);
    RST = 1'b0;
    tick();
    check("rst_clr2", 32'(bus.CLR2), 32'd0);
    check("rst_load", 32'(bus.lane_load), 32'd0);
    check("rst_idx", 32'(bus.lane_idx), 32'd0);
    check("rst_we", 32'(bus.lane_we), 32'd0);
    check("rst_err", 32'(bus.mem_err), 32'd0);

    // Forwarding
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd1; bus.ra1E = 4'd1; bus.ra2E = 4'd3; #1;
    check("fwd_a_m", 32'(bus.ForwardAE), 32'd2);
    check("fwd_b_none", 32'(bus.ForwardBE), 32'd0);
    bus.RegWriteW = 1'b1; bus.WA3W = 4'd1; #1;
    check("fwd_a_m_prio", 32'(bus.ForwardAE), 32'd2);
    bus.RegWriteM = 1'b0; #1;
    check("fwd_a_w", 32'(bus.ForwardAE), 32'd1);
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd5; bus.WA3W = 4'd5; bus.ra2E = 4'd5; #1;
    check("fwd_b_m", 32'(bus.ForwardBE), 32'd2);
    check("fwd_a_none", 32'(bus.ForwardAE), 32'd0);
    bus.RegWriteM = 1'b0; #1;
    check("fwd_b_w", 32'(bus.ForwardBE), 32'd1);
    bus.RegWriteW = 1'b0; #1;
    check("fwd_b_off", 32'(bus.ForwardBE), 32'd0);
    bus.RegWriteM = 1'b1; bus.WA3M = 4'd0; bus.ra1E = 4'd0; #1;
    check("fwd_r0", 32'(bus.ForwardAE), 32'd2);
    bus.RegWriteM = 1'b0;

    // Load-use stall
    tick();
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd2; bus.ra1D = 4'd7; bus.ra2D = 4'd2; #1;
    check("ldu_en", 32'(ens()), 32'h3);
    check("ldu_clr", 32'(bus.CLR2), 32'd1);
    bus.ra2D = 4'd8; #1;
    check("ldu_nomatch", 32'(ens()), 32'hF);
    bus.ra1D = 4'd2; #1;
    check("ldu_ra1", 32'(bus.CLR2), 32'd1);
    tick();
    bus.MemtoRegE = 1'b0; bus.ra1D = 4'd0;
    bus.RegWriteW = 1'b1; bus.WA3W = 4'd2; bus.ra2E = 4'd2; #1;
    check("ldu_after_en", 32'(ens()), 32'hF);
    check("ldu_after_clr", 32'(bus.CLR2), 32'd0);
    check("ldu_fwd_w", 32'(bus.ForwardBE), 32'd1);
    bus.RegWriteW = 1'b0;

    // Vector load, lane_ack every cycle
    tick();
    bus.MemtoRegM = 1'b1; bus.lane_ack = 1'b1;
    bus.MemtoRegE = 1'b1; bus.WA3E = 4'd2; bus.ra2D = 4'd2; #1;
    check("frz_dom_en3", 32'(bus.EN3), 32'd0);
    check("frz_dom_clr", 32'(bus.CLR2), 32'd0);
    check("ld_idle_req", 32'(bus.lane_req), 32'd0);
    check("ld_idle_load", 32'(bus.lane_load), 32'd0);
    bus.MemtoRegE = 1'b0; #1;
    en_low = (bus.EN1 == 1'b0) ? 1 : 0;
    loads = 0;
    for (int c = 1; c <= 9; c++) begin
      tick(); #1;
      if (bus.EN1 == 1'b0) en_low++;
      if (bus.lane_load) loads++;
      if (c <= 8) begin
        check($sformatf("ld_req_%0d", c), 32'(bus.lane_req), 32'd1);
        check($sformatf("ld_idx_%0d", c), 32'(bus.lane_idx), 32'(c - 1));
        check($sformatf("ld_en_%0d", c), 32'(ens()), 32'h0);
      end else begin
        check("ld_done_req", 32'(bus.lane_req), 32'd0);
        check("ld_done_en", 32'(ens()), 32'hF);
        check("ld_done_load", 32'(bus.lane_load), 32'd0);
      end
    end
    check("ld_en_low_cycles", 32'(en_low), 32'd9);
    check("ld_load_pulses", 32'(loads), 32'd8);
    tick();
    bus.MemtoRegM = 1'b0; bus.lane_ack = 1'b0; #1;
    check("ld_after_en", 32'(ens()), 32'hF);

    // Vector store, lane_ack every 3rd cycle
    tick();
    bus.MemWriteM = 1'b1; #1;
    check("st_idle_en", 32'(ens()), 32'h0);
    busy_cnt = 0;
    loads = 0;
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      bus.lane_ack = ((busy_cnt % 3) == 2); #1;
      if (bus.lane_load) loads++;
      if (!bus.lane_req) break;
      if ((busy_cnt % 6) == 0) begin
        check($sformatf("st_idx_%0d", busy_cnt), 32'(bus.lane_idx), 32'(busy_cnt / 3));
        check($sformatf("st_we_%0d", busy_cnt), 32'(bus.lane_we), 32'd1);
      end
      busy_cnt++;
    end
    check("st_busy_cycles", 32'(busy_cnt), 32'd24);
    check("st_no_load", 32'(loads), 32'd0);
    check("st_done_en", 32'(ens()), 32'hF);
    tick();
    bus.MemWriteM = 1'b0; bus.lane_ack = 1'b0;

    // Reset in the middle of a load at lane 4
    tick();
    bus.MemtoRegM = 1'b1; bus.lane_ack = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    #1;
    check("rb_idx4", 32'(bus.lane_idx), 32'd4);
    check("rb_req", 32'(bus.lane_req), 32'd1);
    RST = 1'b1; bus.MemtoRegM = 1'b0; bus.lane_ack = 1'b0; #1;
    check("rb_req_drop", 32'(bus.lane_req), 32'd0);
    check("rb_en", 32'(ens()), 32'hF);
    check("rb_idx0", 32'(bus.lane_idx), 32'd0);
    #1;
    RST = 1'b0;
    tick();
    bus.MemtoRegM = 1'b1;
    tick();
    check("rb_restart_req", 32'(bus.lane_req), 32'd1);
    check("rb_restart_idx", 32'(bus.lane_idx), 32'd0);
    bus.lane_ack = 1'b1;
    cyc = 0;
    while (bus.lane_req && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rb_finish_bound", 32'(bus.lane_req), 32'd0);
    tick();
    bus.MemtoRegM = 1'b0; bus.lane_ack = 1'b0;

`ifdef VEC_HAZARD_TIMEOUT_EN
    // Lane ack never arrives
    tick();
    bus.MemtoRegM = 1'b1;
    busy_cnt = 0;
    loads = 0;
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (bus.lane_load) loads++;
      if (!bus.lane_req) break;
      busy_cnt++;
    end
    check("to_busy_cycles", 32'(busy_cnt), 32'd16);
    check("to_done_en", 32'(ens()), 32'hF);
    check("to_err_set", 32'(bus.mem_err), 32'd1);
    check("to_no_load", 32'(loads), 32'd0);
    tick();
    bus.MemtoRegM = 1'b0;
    tick();
    check("to_err_sticky", 32'(bus.mem_err), 32'd1);
    check("to_idle_req", 32'(bus.lane_req), 32'd0);
`else
    check("no_to_err", 32'(bus.mem_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
